// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver: FSM state encoding
// and parity-mode constants.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    localparam logic PARITY_MODE_EVEN = 1'b0;
    localparam logic PARITY_MODE_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_ovs_if.sv
// Valid/ready stream carrying received words from the receiver FIFO to the sink.
interface uart_rx_ovs_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// Output FIFO for received words; drops a push that finds it full unless a pop
// frees a slot in the same cycle.
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    output logic                  overrun_o,
    uart_rx_ovs_if.master         m_axis
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic                  not_empty, full, pop, wr_en;

    always_comb begin
        not_empty = (count_q != '0);
        full      = (count_q == CNT_FULL);
        pop       = m_axis.ready && not_empty;
        wr_en     = push_i && (!full || pop);
        overrun_o = push_i && full && !pop;
    end

    assign m_axis.valid = not_empty;
    assign m_axis.data  = not_empty ? mem_q[rd_ptr_q] : '0;

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(wr_en) - CNT_W'(pop);
        end
    end

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver: 2-flop line synchronizer, framing FSM clocked by
// os_tick, optional parity/2 stop bits, and a valid/ready output FIFO.
module uart_rx_ovs
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  os_tick,
    input  logic                  rx_in,
    output logic [DATA_WIDTH-1:0] m_axis_data,
    output logic                  m_axis_valid,
    input  logic                  m_axis_ready,
    output logic                  frame_err,
    output logic                  parity_err,
    output logic                  overrun,
    output logic                  busy
);
    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic PAR_MODE = (PARITY_ODD != 0) ? PARITY_MODE_ODD : PARITY_MODE_EVEN;

    logic                  rx_meta_q, rx_sync_q;
    rx_state_t             state_q;
    logic [TICK_W-1:0]     tick_q;
    logic [BIT_W-1:0]      bit_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  parity_bad_q, stop_bad_q, busy_q;
    logic                  stop_final, frame_bad, push;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_in;
            rx_sync_q <= rx_meta_q;
        end
    end

    // bit_q counts data bits, then is reused as the stop-bit counter.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q      <= ST_IDLE;
            tick_q       <= '0;
            bit_q        <= '0;
            data_q       <= '0;
            parity_bad_q <= 1'b0;
            stop_bad_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else if (os_tick) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!rx_sync_q) begin
                        state_q <= ST_START;
                        tick_q  <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (tick_q == TICK_HALF) begin
                        tick_q       <= '0;
                        bit_q        <= '0;
                        parity_bad_q <= 1'b0;
                        stop_bad_q   <= 1'b0;
                        if (rx_sync_q) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_DATA;
                        end
                    end else begin
                        tick_q <= tick_q + TICK_W'(1);
                    end
                end
                ST_DATA: begin
                    if (tick_q == TICK_LAST) begin
                        tick_q <= '0;
                        data_q <= {rx_sync_q, data_q[DATA_WIDTH-1:1]};
                        if (bit_q == BIT_LAST) begin
                            bit_q   <= '0;
                            state_q <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_q <= bit_q + BIT_W'(1);
                        end
                    end else begin
                        tick_q <= tick_q + TICK_W'(1);
                    end
                end
                ST_PARITY: begin
                    if (tick_q == TICK_LAST) begin
                        tick_q       <= '0;
                        parity_bad_q <= (rx_sync_q != ((^data_q) ^ PAR_MODE));
                        state_q      <= ST_STOP;
                    end else begin
                        tick_q <= tick_q + TICK_W'(1);
                    end
                end
                ST_STOP: begin
                    if (tick_q == TICK_LAST) begin
                        tick_q <= '0;
                        if (!rx_sync_q) begin
                            stop_bad_q <= 1'b1;
                        end
                        if (bit_q == STOP_LAST) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            bit_q <= bit_q + BIT_W'(1);
                        end
                    end else begin
                        tick_q <= tick_q + TICK_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Verdict is decoded on the final stop sample so push/flags land in that cycle.
    always_comb begin
        stop_final = os_tick && (state_q == ST_STOP) && (tick_q == TICK_LAST)
                     && (bit_q == STOP_LAST);
        frame_bad  = stop_bad_q || !rx_sync_q;
        frame_err  = stop_final && frame_bad;
        parity_err = stop_final && parity_bad_q;
        push       = stop_final && !frame_bad && !parity_bad_q;
    end

    assign busy = busy_q;

    uart_rx_ovs_if #(.DATA_WIDTH(DATA_WIDTH)) axis_if ();

    assign axis_if.ready = m_axis_ready;
    assign m_axis_data   = axis_if.data;
    assign m_axis_valid  = axis_if.valid;

    uart_rx_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .push_i     (push),
        .push_data_i(data_q),
        .overrun_o  (overrun),
        .m_axis     (axis_if)
    );

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Scoreboard bench for uart_rx_ovs: an 8N1 instance and an 8E1 instance driven
// with directed and random frames against a frame-level reference model.
module tb_uart_rx_ovs;
    localparam int CPT   = 4;          // clocks per os_tick
    localparam int OVS   = 16;
    localparam int CPB   = CPT * OVS;  // clocks per bit
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic os_tick = 1'b0;
    logic rx_a = 1'b1;
    logic rx_p = 1'b1;
    logic fe_a, pe_a, ov_a, busy_a;
    logic fe_p, pe_p, ov_p, busy_p;

    uart_rx_ovs_if #(.DATA_WIDTH(8)) axis_a ();
    uart_rx_ovs_if #(.DATA_WIDTH(8)) axis_p ();

    uart_rx_ovs #(
        .DATA_WIDTH(8), .OVERSAMPLE(OVS), .PARITY_EN(0), .PARITY_ODD(0),
        .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
    ) dut_a (
        .i_clk(clk), .i_rst(rst_n), .os_tick(os_tick), .rx_in(rx_a),
        .m_axis_data(axis_a.data), .m_axis_valid(axis_a.valid), .m_axis_ready(axis_a.ready),
        .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a), .busy(busy_a)
    );

    uart_rx_ovs #(
        .DATA_WIDTH(8), .OVERSAMPLE(OVS), .PARITY_EN(1), .PARITY_ODD(0),
        .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
    ) dut_p (
        .i_clk(clk), .i_rst(rst_n), .os_tick(os_tick), .rx_in(rx_p),
        .m_axis_data(axis_p.data), .m_axis_valid(axis_p.valid), .m_axis_ready(axis_p.ready),
        .frame_err(fe_p), .parity_err(pe_p), .overrun(ov_p), .busy(busy_p)
    );

    always #5 clk = ~clk;

    logic [7:0] exp_a[$];
    logic [7:0] exp_p[$];
    int exp_fe[2], exp_pe[2], exp_ov[2];
    int obs_fe[2], obs_pe[2], obs_ov[2], beats[2];
    logic       prev_hold[2];
    logic [7:0] prev_data[2];
    int errors = 0;
    int checks = 0;
    int ready_mode_a = 0;  // 0 low, 1 high, 2 random

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    // Tick and ready are driven just after the rising edge.
    initial begin
        int ph;
        ph = 0;
        axis_a.ready = 1'b0;
        axis_p.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ph = (ph + 1) % CPT;
            os_tick = (ph == 0);
            case (ready_mode_a)
                0:       axis_a.ready = 1'b0;
                1:       axis_a.ready = 1'b1;
                default: axis_a.ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic mon_dut(input int d, input logic v, input logic r, input logic [7:0] data,
                           input logic fe, input logic pe, input logic ov);
        string sfx;
        logic [7:0] want;
        int qs;
        if (d == 0) sfx = "a"; else sfx = "p";
        if (prev_hold[d]) begin
            check({"hold_valid_", sfx}, int'(v), 1);
            check({"hold_data_", sfx}, int'(data), int'(prev_data[d]));
        end
        prev_hold[d] = v && !r;
        prev_data[d] = data;
        if (v && r) begin
            beats[d]++;
            qs = (d == 0) ? exp_a.size() : exp_p.size();
            check({"beat_expected_", sfx}, int'(qs != 0), 1);
            if (qs != 0) begin
                if (d == 0) want = exp_a.pop_front();
                else        want = exp_p.pop_front();
                check({"data_", sfx}, int'(data), int'(want));
            end
        end
        if (fe) obs_fe[d]++;
        if (pe) obs_pe[d]++;
        if (ov) obs_ov[d]++;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold[0] = 1'b0;
            prev_hold[1] = 1'b0;
        end else begin
            mon_dut(0, axis_a.valid, axis_a.ready, axis_a.data, fe_a, pe_a, ov_a);
            mon_dut(1, axis_p.valid, axis_p.ready, axis_p.data, fe_p, pe_p, ov_p);
        end
    end

    // Frame-level model: a clean frame enters the FIFO if room, else counts as overrun.
    task automatic predict(input int d, input logic [7:0] data, input logic par_flip,
                           input logic stop_low);
        int occ;
        if (stop_low) exp_fe[d]++;
        if (par_flip) exp_pe[d]++;
        if (!stop_low && !par_flip) begin
            occ = (d == 0) ? exp_a.size() : exp_p.size();
            if (occ >= DEPTH) exp_ov[d]++;
            else if (d == 0) exp_a.push_back(data);
            else exp_p.push_back(data);
        end
    endtask

    task automatic drive_bit(input int d, input logic b, input int cycles);
        if (d == 0) rx_a = b; else rx_p = b;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic send_frame(input int d, input logic [7:0] data, input logic par_flip,
                              input logic stop_low);
        logic par;
        predict(d, data, par_flip, stop_low);
        drive_bit(d, 1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bit(d, data[i], CPB);
        if (d == 1) begin
            par = ^data;
            if (par_flip) par = ~par;
            drive_bit(d, par, CPB);
        end
        drive_bit(d, !stop_low, CPB);
        if (stop_low) drive_bit(d, 1'b1, 2 * CPB);
    endtask

    task automatic checkpoint(input string ph);
        repeat (CPB) @(negedge clk);
        for (int n = 0; n < 40 * CPB && (exp_a.size() != 0 || exp_p.size() != 0); n++)
            @(negedge clk);
        check({ph, " pending_a"}, exp_a.size(), 0);
        check({ph, " pending_p"}, exp_p.size(), 0);
        check({ph, " frame_err_a"}, obs_fe[0], exp_fe[0]);
        check({ph, " frame_err_p"}, obs_fe[1], exp_fe[1]);
        check({ph, " parity_err_a"}, obs_pe[0], exp_pe[0]);
        check({ph, " parity_err_p"}, obs_pe[1], exp_pe[1]);
        check({ph, " overrun_a"}, obs_ov[0], exp_ov[0]);
        check({ph, " overrun_p"}, obs_ov[1], exp_ov[1]);
        check({ph, " busy_a"}, int'(busy_a), 0);
        check({ph, " busy_p"}, int'(busy_p), 0);
    endtask

    task automatic check_reset_state(input string ph);
        check({ph, " valid_a"}, int'(axis_a.valid), 0);
        check({ph, " data_a"}, int'(axis_a.data), 0);
        check({ph, " fe_a"}, int'(fe_a), 0);
        check({ph, " pe_a"}, int'(pe_a), 0);
        check({ph, " ov_a"}, int'(ov_a), 0);
        check({ph, " busy_a"}, int'(busy_a), 0);
        check({ph, " valid_p"}, int'(axis_p.valid), 0);
        check({ph, " busy_p"}, int'(busy_p), 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic busy_seen;
        for (int d = 0; d < 2; d++) begin
            exp_fe[d] = 0; exp_pe[d] = 0; exp_ov[d] = 0;
            obs_fe[d] = 0; obs_pe[d] = 0; obs_ov[d] = 0; beats[d] = 0;
            prev_hold[d] = 1'b0; prev_data[d] = '0;
        end

        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;
        repeat (CPB) @(negedge clk);

        ready_mode_a = 1;
        send_frame(0, 8'hA5, 1'b0, 1'b0);
        checkpoint("a5");
        check("a5 beats_a", beats[0], 1);

        busy_seen = 1'b0;
        rx_a = 1'b0;
        repeat (3 * CPT) begin
            @(negedge clk);
            if (busy_a) busy_seen = 1'b1;
        end
        rx_a = 1'b1;
        for (int c = 0; c < 9 * CPT && busy_a; c++) @(negedge clk);
        check("glitch busy_seen", int'(busy_seen), 1);
        check("glitch busy_clear", int'(busy_a), 0);
        checkpoint("glitch");
        check("glitch beats_a", beats[0], 1);

        send_frame(0, 8'h3C, 1'b0, 1'b1);
        checkpoint("stop_low");
        check("stop_low valid_a", int'(axis_a.valid), 0);

        send_frame(1, 8'h5A, 1'b1, 1'b0);
        checkpoint("par_bad");
        check("par_bad valid_p", int'(axis_p.valid), 0);
        check("par_bad beats_p", beats[1], 0);
        send_frame(1, 8'h5A, 1'b0, 1'b0);
        checkpoint("par_ok");
        check("par_ok beats_p", beats[1], 1);

        ready_mode_a = 0;
        repeat (4) @(negedge clk);
        for (int v = 1; v <= 5; v++) send_frame(0, 8'(v), 1'b0, 1'b0);
        repeat (CPB) @(negedge clk);
        check("ovr pulses_before_drain", obs_ov[0], exp_ov[0]);
        check("ovr valid_held", int'(axis_a.valid), 1);
        check("ovr beats_before_drain", beats[0], 1);
        ready_mode_a = 1;
        checkpoint("overrun");
        check("overrun beats_a", beats[0], 5);

        drive_bit(0, 1'b0, CPB);
        for (int i = 0; i < 4; i++) drive_bit(0, 1'b1, CPB);
        drive_bit(0, 1'b1, CPB / 2);
        check("rst_mid busy_before", int'(busy_a), 1);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("rst_mid");
        rst_n = 1'b1;
        drive_bit(0, 1'b1, CPB / 2 + 5 * CPB);
        check("rst_mid idle_after", int'(busy_a), 0);
        send_frame(0, 8'h81, 1'b0, 1'b0);
        checkpoint("rst_mid");
        check("rst_mid beats_a", beats[0], 6);

        ready_mode_a = 2;
        repeat (20) send_frame(0, 8'($urandom), 1'b0, 1'($urandom_range(0, 4) == 0));
        checkpoint("rand_a");
        repeat (10) send_frame(1, 8'($urandom), 1'($urandom_range(0, 3) == 0),
                               1'($urandom_range(0, 5) == 0));
        checkpoint("rand_p");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_ovs.md
UART_RX_OVS -- requirements
Module: uart_rx_ovs

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning data bits per frame (legal range 5..9).
REQ-002 SHALL have parameter OVERSAMPLE, default 16, meaning ticks per bit period (even, range 8..32).
REQ-003 SHALL have parameter PARITY_EN, default 0, meaning a parity bit follows the data bits when set to 1.
REQ-004 SHALL have parameter PARITY_ODD, default 0, meaning odd parity when 1 and even parity when 0; ignored when PARITY_EN=0.
REQ-005 SHALL have parameter STOP_BITS, default 1, meaning the number of stop bits (legal values 1 or 2).
REQ-006 SHALL have parameter FIFO_DEPTH, default 4, meaning the output FIFO depth (power of 2, minimum 2).
REQ-007 SHALL have port i_clk, input, 1 bit: the clock.
REQ-008 SHALL have port i_rst, input, 1 bit: reset, synchronous, active-low.
REQ-009 SHALL have port os_tick, input, 1 bit: single-cycle enable at OVERSAMPLE x baud rate.
REQ-010 SHALL have port rx_in, input, 1 bit: asynchronous serial line, idle high.
REQ-011 SHALL have port m_axis_data, output, DATA_WIDTH bits: received word, LSB = first bit on the line.
REQ-012 SHALL have port m_axis_valid, output, 1 bit: the FIFO holds at least one word.
REQ-013 SHALL have port m_axis_ready, input, 1 bit: sink accepts the word.
REQ-014 SHALL have port frame_err, output, 1 bit: one-cycle pulse when any stop bit samples low.
REQ-015 SHALL have port parity_err, output, 1 bit: one-cycle pulse when parity mismatches.
REQ-016 SHALL have port overrun, output, 1 bit: one-cycle pulse when a good word is dropped because the FIFO is full.
REQ-017 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-018 SHALL pass rx_in through a 2-flop synchronizer reset to 1, and use only the synchronized value.
REQ-019 SHALL implement states IDLE, START, DATA, PARITY, STOP; all counting advances only on os_tick.
REQ-020 IDLE: on os_tick with a low synchronized line, SHALL go to START and clear the tick counter.
REQ-021 START: after OVERSAMPLE/2 ticks, SHALL resample; low goes to DATA, high (glitch) goes back to IDLE with no flag.
REQ-022 DATA: SHALL sample once every OVERSAMPLE ticks, storing bit n at index n, LSB first; after DATA_WIDTH samples, SHALL go to PARITY if PARITY_EN=1, else STOP.
REQ-023 PARITY: SHALL sample after OVERSAMPLE ticks; mismatch versus XOR of the data bits (inverted if PARITY_ODD) SHALL mark the frame bad.
REQ-024 STOP: SHALL sample STOP_BITS times at OVERSAMPLE-tick spacing; any low sample SHALL mark a framing error.
REQ-025 On the final stop sample, SHALL return to IDLE in the same tick (mid-stop-bit), so back-to-back frames are received.
REQ-026 Good frame: SHALL push to the FIFO on the final stop-sample cycle; m_axis_valid SHALL rise on the next cycle when the FIFO was empty.
REQ-027 Bad frame: SHALL NOT push; SHALL pulse frame_err and/or parity_err on the final stop-sample cycle, with both pulsing if both errors occur.
REQ-028 SHALL complete a transfer on a cycle with m_axis_valid and m_axis_ready both high; m_axis_data SHALL stay stable while valid is high and ready is low.
REQ-029 Push to a full FIFO with no pop that cycle: SHALL drop the word and pulse overrun.
REQ-030 Push to a full FIFO with a simultaneous pop: SHALL accept the word with no overrun.
REQ-031 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with a separate count register of width clog2(FIFO_DEPTH)+1.
REQ-032 SHALL size the tick counter at clog2(OVERSAMPLE) bits and the bit counter at clog2(DATA_WIDTH+1) bits.

Reset
REQ-033 On i_rst=0 at a clock edge, SHALL set the state to IDLE, clear all counters, and empty the FIFO.
REQ-034 Reset values: m_axis_valid 0, m_axis_data 0, frame_err 0, parity_err 0, overrun 0, busy 0.
REQ-035 Reset mid-frame SHALL discard the partial frame; reception resumes at the next falling edge after release.

Structure
REQ-036 SHALL define the state encoding and the parity-mode constants in shared package uart_pkg.
REQ-037 SHALL instantiate the FIFO as sub-module uart_rx_fifo, parameterised by DATA_WIDTH and FIFO_DEPTH.

Verification
REQ-038 Bench SHALL check: 8N1 at 16x, byte 0xA5, ready high -> a single valid beat with data 0xA5 and no error pulses.
REQ-039 Bench SHALL check: 3-tick low glitch on an idle line -> no valid beat, no flags, busy back to 0 within 9 ticks.
REQ-040 Bench SHALL check: 0x3C with stop bit forced low -> frame_err pulses once and the FIFO stays empty.
REQ-041 Bench SHALL check: PARITY_EN=1 even, 0x5A sent with parity bit 1 -> parity_err pulses and no data; then 0x5A with parity bit 0 -> data 0x5A.
REQ-042 Bench SHALL check: FIFO_DEPTH=4, ready low, back-to-back 0x01..0x05 -> overrun pulses once on 0x05; with ready then raised, the output drains 0x01..0x04 in order.
REQ-043 Bench SHALL check: i_rst low during bit 4 of 0xFF, then 0x81 after release -> only 0x81 appears.
